// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the MEM-stage load/store path.
// One request at a time over valid/ready, LATENCY wait states, then a
// single-cycle response strobe. Byte/half/word access with RV32 funct3.
module dmem_responder #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] BASE    = 32'h1001_0000,
    parameter int          LATENCY = 1
) (
    input  logic        clockMem,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        cap_we_q;
    logic [31:0] cap_addr_q;
    logic [31:0] cap_wdata_q;
    logic [2:0]  cap_f3_q;

    logic [31:0] mem_q [DEPTH];

    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // Operation being executed: with zero latency the request executes on
    // the accepting edge, so the live inputs are used while still in IDLE.
    logic        op_we;
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_f3;
    logic [1:0]  off;
    logic [31:0] rel;
    logic [ADDR_W-1:0] idx;
    logic        in_range, f3_ok, align_ok, fault, exec;
    logic [31:0] rd_word, ld_data, wr_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  wr_be;

    assign op_we    = (state_q == S_IDLE) ? req_we     : cap_we_q;
    assign op_addr  = (state_q == S_IDLE) ? req_addr   : cap_addr_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata  : cap_wdata_q;
    assign op_f3    = (state_q == S_IDLE) ? req_funct3 : cap_f3_q;

    assign off      = op_addr[1:0];
    assign rel      = op_addr - BASE;
    assign idx      = rel[ADDR_W+1:2];
    assign in_range = (op_addr >= BASE) && ((rel >> (ADDR_W + 2)) == 32'd0);
    assign fault    = !in_range || !f3_ok || !align_ok;
    assign rd_word  = mem_q[idx];

    // Storage and read capture happen on the edge that enters RESP.
    assign exec     = (state_d == S_RESP);

    // Decode legality, lane selection and load extension.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        rd_byte  = 8'd0;
        rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data  = 32'd0;
        wr_be    = 4'b0000;
        wr_data  = op_wdata;

        if (op_we) f3_ok = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010);
        else       f3_ok = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010) ||
                           (op_f3 == 3'b100) || (op_f3 == 3'b101);

        if (op_f3[1:0] == 2'b01) align_ok = !off[0];
        if (op_f3[1:0] == 2'b10) align_ok = (off == 2'b00);

        case (off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase

        case (op_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = 32'd0;
        endcase

        // Store data is replicated across lanes; byte enables pick the lane.
        case (op_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << off;
                wr_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op_wdata[15:0]}};
            end
            default: wr_be = 4'b1111;
        endcase
    end

    // FSM state and wait counter register.
    always_ff @(posedge clockMem) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, response strobe only in RESP.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    // Capture the request on the accepting edge.
    always_ff @(posedge clockMem) begin
        if (state_q == S_IDLE && req_valid) begin
            cap_we_q    <= req_we;
            cap_addr_q  <= req_addr;
            cap_wdata_q <= req_wdata;
            cap_f3_q    <= req_funct3;
        end
    end

    // Storage write; never cleared, and a reset at the RESP edge blocks it.
    always_ff @(posedge clockMem) begin
        if (reset && exec && op_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Registered response data/error, held until the next response.
    always_ff @(posedge clockMem) begin
        if (!reset) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (exec) begin
            rsp_rdata_q <= (op_we || fault) ? 32'd0 : ld_data;
            rsp_err_q   <= fault;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
